// File: rtl/stage_mem.sv
// stage_mem: memory-access stage of the 5-stage core.
// Issues load/store requests on the data bus and supports wait states.
// Load data is lane-aligned and extended here. The stage owns the MEM/WB
// register that feeds write-back. Upstream is stalled while an access is
// outstanding.
module stage_mem #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_isValid,
    input  logic [DATA_WIDTH-1:0]     i_result,
    input  logic [DATA_WIDTH-1:0]     i_memWrData,
    input  logic                      i_memRead,
    input  logic                      i_memWrite,
    input  logic [1:0]                i_memSize,
    input  logic                      i_memUnsigned,
    input  logic [REG_ADDR_WIDTH-1:0] i_regWrAddr,
    input  logic                      i_regWrEnable,
    output logic [ADDR_WIDTH-1:0]     o_memAddr,
    output logic [DATA_WIDTH-1:0]     o_memWrData,
    output logic [3:0]                o_memByteEnable,
    output logic                      o_memRd,
    output logic                      o_memWr,
    input  logic [DATA_WIDTH-1:0]     i_memRdData,
    input  logic                      i_memReady,
    output logic                      o_stall,
    output logic                      o_hazard,
    output logic                      o_misaligned,
    output logic                      o_isValid,
    output logic [DATA_WIDTH-1:0]     o_regWrData,
    output logic [REG_ADDR_WIDTH-1:0] o_regWrAddr,
    output logic                      o_regWrEnable
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_r;
    state_t nextState_s;

    logic                  aligned_s;
    logic                  isMemOp_s;
    logic                  access_s;
    logic                  misalign_s;
    logic                  stall_s;
    logic [DATA_WIDTH-1:0] loadData_s;

    // Half accesses need an even address, words a 4-byte-aligned one;
    // the reserved size code behaves like a word.
    function automatic logic isAligned(input logic [1:0] off, input logic [1:0] size);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] loadAlign(input logic [31:0] raw, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Replicate store data so every candidate lane carries the value.
    function automatic logic [31:0] storeLanes(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{data[7:0]}};
            2'b01:   res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

    // Byte-lane enables for the addressed bytes.
    function automatic logic [3:0] byteEnable(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Access qualification, bus request and stall; reset silences the bus.
    always_comb begin
        aligned_s       = isAligned(i_result[1:0], i_memSize);
        isMemOp_s       = i_isValid & (i_memRead | i_memWrite);
        access_s        = isMemOp_s & aligned_s;
        misalign_s      = isMemOp_s & ~aligned_s;
        stall_s         = i_reset & access_s & ~i_memReady;
        loadData_s      = loadAlign(i_memRdData, i_result[1:0], i_memSize, i_memUnsigned);
        o_memAddr       = {i_result[ADDR_WIDTH-1:2], 2'b00};
        o_memWrData     = storeLanes(i_memWrData, i_memSize);
        o_memRd         = i_reset & access_s & i_memRead;
        o_memWr         = i_reset & access_s & i_memWrite;
        o_stall         = stall_s;
        o_hazard        = i_reset & i_isValid & i_memRead & i_regWrEnable
                          & (i_regWrAddr != {REG_ADDR_WIDTH{1'b0}})
                          & ((state_r == WAIT) | ~i_memReady);
        if (access_s) begin
            o_memByteEnable = byteEnable(i_result[1:0], i_memSize);
        end else begin
            o_memByteEnable = 4'b0000;
        end
    end

    // Next state: wait in WAIT until the bus reports ready.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_s && !i_memReady) begin
                    nextState_s = WAIT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (i_memReady || !access_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // MEM/WB register: bubble while stalled or idle, else capture the result.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_isValid     <= 1'b0;
            o_misaligned  <= 1'b0;
            o_regWrEnable <= 1'b0;
            o_regWrAddr   <= {REG_ADDR_WIDTH{1'b0}};
            o_regWrData   <= {DATA_WIDTH{1'b0}};
        end else if (stall_s || !i_isValid) begin
            o_isValid     <= 1'b0;
            o_misaligned  <= 1'b0;
            o_regWrEnable <= 1'b0;
        end else begin
            o_isValid     <= 1'b1;
            o_misaligned  <= misalign_s;
            // Stores and faulting accesses never write a GPR.
            o_regWrEnable <= i_regWrEnable & ~misalign_s & ~i_memWrite;
            o_regWrAddr   <= i_regWrAddr;
            if (access_s && i_memRead) begin
                o_regWrData <= loadData_s;
            end else begin
                o_regWrData <= i_result;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed self-checking bench for stage_mem.
module tb_stage_mem;

    logic        i_clock;
    logic        i_reset;
    logic        i_isValid;
    logic [31:0] i_result;
    logic [31:0] i_memWrData;
    logic        i_memRead;
    logic        i_memWrite;
    logic [1:0]  i_memSize;
    logic        i_memUnsigned;
    logic [4:0]  i_regWrAddr;
    logic        i_regWrEnable;
    logic [31:0] o_memAddr;
    logic [31:0] o_memWrData;
    logic [3:0]  o_memByteEnable;
    logic        o_memRd;
    logic        o_memWr;
    logic [31:0] i_memRdData;
    logic        i_memReady;
    logic        o_stall;
    logic        o_hazard;
    logic        o_misaligned;
    logic        o_isValid;
    logic [31:0] o_regWrData;
    logic [4:0]  o_regWrAddr;
    logic        o_regWrEnable;

    int nCompared;
    int nMismatched;

    stage_mem dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_isValid       (i_isValid),
        .i_result        (i_result),
        .i_memWrData     (i_memWrData),
        .i_memRead       (i_memRead),
        .i_memWrite      (i_memWrite),
        .i_memSize       (i_memSize),
        .i_memUnsigned   (i_memUnsigned),
        .i_regWrAddr     (i_regWrAddr),
        .i_regWrEnable   (i_regWrEnable),
        .o_memAddr       (o_memAddr),
        .o_memWrData     (o_memWrData),
        .o_memByteEnable (o_memByteEnable),
        .o_memRd         (o_memRd),
        .o_memWr         (o_memWr),
        .i_memRdData     (i_memRdData),
        .i_memReady      (i_memReady),
        .o_stall         (o_stall),
        .o_hazard        (o_hazard),
        .o_misaligned    (o_misaligned),
        .o_isValid       (o_isValid),
        .o_regWrData     (o_regWrData),
        .o_regWrAddr     (o_regWrAddr),
        .o_regWrEnable   (o_regWrEnable)
    );

    // 10 ns clock.
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared = nCompared + 1;
        if (observed !== expected) begin
            nMismatched = nMismatched + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setOp(input logic valid, input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] result, input logic [31:0] wdata,
                         input logic [4:0] rdAddr, input logic wen);
        i_isValid     = valid;
        i_memRead     = rd;
        i_memWrite    = wr;
        i_memSize     = size;
        i_memUnsigned = uns;
        i_result      = result;
        i_memWrData   = wdata;
        i_regWrAddr   = rdAddr;
        i_regWrEnable = wen;
    endtask

    task automatic afterEdge();
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        i_reset     = 1'b0;
        i_memRdData = 32'h0000_0000;
        i_memReady  = 1'b0;
        // A load request is presented during reset: the bus must stay quiet.
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
        repeat (2) @(posedge i_clock);
        #1;
        checkVal("rst_isValid", {31'b0, o_isValid}, 32'd0);
        checkVal("rst_regWrData", o_regWrData, 32'd0);
        checkVal("rst_memRd", {31'b0, o_memRd}, 32'd0);
        checkVal("rst_stall", {31'b0, o_stall}, 32'd0);
        checkVal("rst_hazard", {31'b0, o_hazard}, 32'd0);

        @(negedge i_clock);
        setOp(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        i_reset = 1'b1;

        // Non-memory op passes straight through.
        @(negedge i_clock);
        setOp(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_002A, 32'h0, 5'd5, 1'b1);
        #1;
        checkVal("alu_memRd", {31'b0, o_memRd}, 32'd0);
        checkVal("alu_memWr", {31'b0, o_memWr}, 32'd0);
        checkVal("alu_stall", {31'b0, o_stall}, 32'd0);
        afterEdge();
        checkVal("alu_isValid", {31'b0, o_isValid}, 32'd1);
        checkVal("alu_data", o_regWrData, 32'h0000_002A);
        checkVal("alu_addr", {27'b0, o_regWrAddr}, 32'd5);
        checkVal("alu_wen", {31'b0, o_regWrEnable}, 32'd1);

        // LW with a ready bus in the same cycle.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd6, 1'b1);
        i_memRdData = 32'hDEAD_BEEF;
        i_memReady  = 1'b1;
        #1;
        checkVal("lw_addr", o_memAddr, 32'h0000_0100);
        checkVal("lw_be", {28'b0, o_memByteEnable}, 32'hF);
        checkVal("lw_memRd", {31'b0, o_memRd}, 32'd1);
        checkVal("lw_stall", {31'b0, o_stall}, 32'd0);
        checkVal("lw_hazard", {31'b0, o_hazard}, 32'd0);
        afterEdge();
        checkVal("lw_data", o_regWrData, 32'hDEAD_BEEF);
        checkVal("lw_isValid", {31'b0, o_isValid}, 32'd1);

        // LB / LBU at byte offset 3.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd6, 1'b1);
        i_memRdData = 32'h8000_0000;
        #1;
        checkVal("lb_addr", o_memAddr, 32'h0000_0100);
        checkVal("lb_be", {28'b0, o_memByteEnable}, 32'h8);
        afterEdge();
        checkVal("lb_data", o_regWrData, 32'hFFFF_FF80);
        @(negedge i_clock);
        i_memUnsigned = 1'b1;
        afterEdge();
        checkVal("lbu_data", o_regWrData, 32'h0000_0080);

        // LH at offset 2, signed.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 5'd6, 1'b1);
        i_memRdData = 32'h8001_7777;
        afterEdge();
        checkVal("lh_data", o_regWrData, 32'hFFFF_8001);

        // SH at 0x202.
        @(negedge i_clock);
        setOp(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_1234, 5'd0, 1'b0);
        #1;
        checkVal("sh_wdata", o_memWrData, 32'h1234_1234);
        checkVal("sh_be", {28'b0, o_memByteEnable}, 32'hC);
        checkVal("sh_memWr", {31'b0, o_memWr}, 32'd1);
        checkVal("sh_memRd", {31'b0, o_memRd}, 32'd0);
        afterEdge();
        checkVal("sh_wen", {31'b0, o_regWrEnable}, 32'd0);
        checkVal("sh_isValid", {31'b0, o_isValid}, 32'd1);

        // Misaligned SH at 0x201: no write request.
        @(negedge i_clock);
        i_result = 32'h0000_0201;
        #1;
        checkVal("shmis_memWr", {31'b0, o_memWr}, 32'd0);
        afterEdge();
        checkVal("shmis_misaligned", {31'b0, o_misaligned}, 32'd1);

        // LW with three wait states.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 5'd7, 1'b1);
        i_memReady  = 1'b0;
        i_memRdData = 32'h1122_3344;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkVal($sformatf("wait%0d_stall", k), {31'b0, o_stall}, 32'd1);
            checkVal($sformatf("wait%0d_hazard", k), {31'b0, o_hazard}, 32'd1);
            checkVal($sformatf("wait%0d_memRd", k), {31'b0, o_memRd}, 32'd1);
            afterEdge();
            checkVal($sformatf("wait%0d_bubble", k), {31'b0, o_isValid}, 32'd0);
            checkVal($sformatf("wait%0d_wen", k), {31'b0, o_regWrEnable}, 32'd0);
            @(negedge i_clock);
        end
        i_memReady = 1'b1;
        #1;
        checkVal("ready_stall", {31'b0, o_stall}, 32'd0);
        checkVal("ready_hazard", {31'b0, o_hazard}, 32'd1);
        afterEdge();
        checkVal("ready_isValid", {31'b0, o_isValid}, 32'd1);
        checkVal("ready_data", o_regWrData, 32'h1122_3344);
        @(negedge i_clock);
        setOp(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        afterEdge();
        checkVal("ready_onePulse", {31'b0, o_isValid}, 32'd0);

        // Misaligned LW at 0x101.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd8, 1'b1);
        #1;
        checkVal("lwmis_memRd", {31'b0, o_memRd}, 32'd0);
        checkVal("lwmis_stall", {31'b0, o_stall}, 32'd0);
        afterEdge();
        checkVal("lwmis_isValid", {31'b0, o_isValid}, 32'd1);
        checkVal("lwmis_misaligned", {31'b0, o_misaligned}, 32'd1);
        checkVal("lwmis_wen", {31'b0, o_regWrEnable}, 32'd0);

        // Reset asserted while in WAIT.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 5'd9, 1'b1);
        i_memReady = 1'b0;
        afterEdge();
        checkVal("prerst_stall", {31'b0, o_stall}, 32'd1);
        #1;
        i_reset = 1'b0;
        #1;
        checkVal("rstwait_memRd", {31'b0, o_memRd}, 32'd0);
        checkVal("rstwait_stall", {31'b0, o_stall}, 32'd0);
        checkVal("rstwait_regWrData", o_regWrData, 32'd0);
        @(negedge i_clock);
        setOp(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        i_reset = 1'b1;
        afterEdge();
        checkVal("post_isValid", {31'b0, o_isValid}, 32'd0);
        checkVal("post_regWrData", o_regWrData, 32'd0);
        checkVal("post_misaligned", {31'b0, o_misaligned}, 32'd0);
        // A ready load in IDLE raises no hazard; in WAIT it would.
        @(negedge i_clock);
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 5'd9, 1'b1);
        i_memReady = 1'b1;
        #1;
        checkVal("post_idleHazard", {31'b0, o_hazard}, 32'd0);
        checkVal("post_stall", {31'b0, o_stall}, 32'd0);
        afterEdge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
Memory-access stage of the 5-stage core. It sits between EX and WB: it takes the EX result, performs load/store transactions on the data-memory bus with wait-state support, and aligns/extends load data. It owns the MEM/WB pipeline register that directly feeds the write-back stage. It stalls upstream while a bus access is outstanding.

Parameters:
DATA_WIDTH, 32, register/bus data width (only 32 supported)
ADDR_WIDTH, 32, data bus address width
REG_ADDR_WIDTH, 5, GPR address width

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_isValid  in  1  EX presents a valid instruction
i_result  in  DATA_WIDTH  ALU result: effective address for load/store, else write-back value
i_memWrData  in  DATA_WIDTH  store data (rs2)
i_memRead  in  1  instruction is a load
i_memWrite  in  1  instruction is a store (never both with i_memRead)
i_memSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_memUnsigned  in  1  zero-extend load (LBU/LHU)
i_regWrAddr  in  REG_ADDR_WIDTH  destination GPR
i_regWrEnable  in  1  instruction writes a GPR
o_memAddr  out  ADDR_WIDTH  bus address, word-aligned (low 2 bits 0)
o_memWrData  out  DATA_WIDTH  store data replicated to lanes
o_memByteEnable  out  4  byte lanes
o_memRd  out  1  read request
o_memWr  out  1  write request
i_memRdData  in  DATA_WIDTH  read data, valid when i_memReady
i_memReady  in  1  bus completes the current request this cycle
o_stall  out  1  upstream must hold all inputs stable
o_hazard  out  1  load in flight targets a nonzero GPR (load-use detection)
o_misaligned  out  1  registered: instruction in MEM/WB took an alignment fault
o_isValid  out  1  registered: valid op to WB
o_regWrData  out  DATA_WIDTH  registered write-back data
o_regWrAddr  out  REG_ADDR_WIDTH  registered destination
o_regWrEnable  out  1  registered write enable

Behaviour:
- Reset (i_reset=0, asynchronous): FSM to IDLE; all registered outputs 0; o_memRd, o_memWr, o_stall, o_hazard forced 0 combinationally while reset is held.
- FSM states: IDLE, WAIT.
- Access condition: i_isValid & (i_memRead | i_memWrite) & aligned. Aligned means: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
- IDLE with access: bus request driven combinationally from the inputs.
  - If i_memReady is high the same cycle: result captured at the next edge, no stall, stay in IDLE.
  - Otherwise: o_stall=1, go to WAIT.
- WAIT: request held (inputs are stable because of the stall) and o_stall=1 until i_memReady. On the ready cycle: o_stall=0, capture at the edge, return to IDLE.
- While o_stall=1, each edge loads a bubble into MEM/WB: o_isValid=0, o_regWrEnable=0.
- Non-memory valid op: passes through in 1 cycle.
  - o_regWrData=i_result; address and enable copied from the inputs.
- Misaligned load/store:
  - No bus request, no stall.
  - Next cycle: o_isValid=1, o_misaligned=1, o_regWrEnable=0.
- Store lanes:
  - Byte: data[7:0] replicated ×4, BE=1<<addr[1:0].
  - Half: data[15:0] replicated ×2, BE=0011 or 1100 by addr[1].
  - Word: data as-is, BE=1111.
- Load lanes:
  - Lane selected by addr[1:0].
  - Sign- or zero-extended per i_memUnsigned; word loads are passed as-is.
  - The extended value is captured into o_regWrData.
- Invalid input (i_isValid=0): no request; bubble is loaded.
- o_hazard = i_isValid & i_memRead & i_regWrEnable & (i_regWrAddr!=0) & (state==WAIT | ~i_memReady).
- Latency: 1 cycle plus wait states; exactly one o_isValid pulse per accepted instruction.
- i_memReady outside a request: ignored.

Test Plan:
- Non-memory op, i_result=0x0000002A, rd=5, memory idle -> next cycle o_isValid=1, o_regWrData=0x2A, o_regWrAddr=5, no bus request, o_stall=0.
- LW @0x100, i_memRdData=0xDEADBEEF, ready same cycle -> o_memAddr=0x100, BE=1111; next cycle o_regWrData=0xDEADBEEF, o_isValid=1.
- LB @0x103, rdData=0x80000000 -> o_regWrData=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH @0x202 of data 0x00001234 -> o_memWrData=0x12341234, BE=1100, o_memWr=1; o_regWrEnable=0 next cycle.
- LW with i_memReady low for 3 cycles -> o_stall=1 for exactly 3 cycles, o_hazard=1 during them (rd≠0), bubbles in MEM/WB; one o_isValid pulse after ready.
- LW @0x101 -> no o_memRd, o_misaligned=1, o_regWrEnable=0. Reset asserted in WAIT -> o_memRd and o_stall drop immediately; after release, FSM in IDLE with all outputs 0.
